// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide sequencer
package muldiv_pkg;
  localparam int MD_XLEN = 32;
  localparam int MD_ITER = MD_XLEN;
  localparam logic [6:0] MD_FUNCT7 = 7'b0000001;
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } mdop_t;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} mdstate_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add (multiply) or trial-subtract (divide) iteration
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN:0]     rem,
  input  logic [XLEN-1:0]   opb,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic [XLEN:0]     rem_nxt
);
  logic [XLEN:0] sum, shl, dif;
  always_comb begin
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    shl = {rem[XLEN-1:0], acc[XLEN-1]};
    // top bit of the difference doubles as the borrow since rem < divisor
    dif = shl - {1'b0, opb};
    acc_nxt = div ? {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], ~dif[XLEN]} : {sum, acc[XLEN-1:1]};
    rem_nxt = div ? (dif[XLEN] ? shl : dif) : rem;
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer with FSM, sign handling and fixup
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN         = MD_XLEN,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);
  mdstate_t state;
  mdop_t op;
  logic [CW-1:0] cnt;
  logic [2*XLEN-1:0] acc, acc_nxt, wide;
  logic [XLEN:0] rem, rem_nxt;
  logic [XLEN-1:0] opb, ma, mb, dword, res;
  logic neg, sa, sb, sgn, bz, ovf, accept, fast;
  muldiv_step #(.XLEN(XLEN)) u_step (
    .div(op[2]), .acc(acc), .rem(rem), .opb(opb), .acc_nxt(acc_nxt), .rem_nxt(rem_nxt)
  );
  always_comb begin
    accept = start_i & ~flush_i & (state == IDLE || state == DONE);
    stall_o = accept | (state == CALC) | (state == FIXUP);
    sa = a_i[XLEN-1] & (funct3_i inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    sb = b_i[XLEN-1] & (funct3_i inside {MD_MULH, MD_DIV, MD_REM});
    ma = sa ? -a_i : a_i;
    mb = sb ? -b_i : b_i;
    bz = b_i == '0;
    ovf = sa & sb & (ma == {1'b1, {(XLEN-1){1'b0}}}) & (mb == XLEN'(1));
    fast = FAST_SPECIAL & funct3_i[2] & (bz | ovf);
    // a zero divisor must leave the all-ones quotient un-negated
    sgn = funct3_i[2] ? (funct3_i[1] ? sa : (sa ^ sb) & ~bz) : (sa ^ sb);
    wide = neg ? -acc : acc;
    dword = op[1] ? rem[XLEN-1:0] : acc[XLEN-1:0];
    res = op[2] ? (neg ? -dword : dword) : (op[1:0] == 2'b00 ? wide[XLEN-1:0] : wide[2*XLEN-1:XLEN]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op <= MD_MUL;
      cnt <= '0;
      acc <= '0;
      rem <= '0;
      opb <= '0;
      neg <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      result_o <= '0;
    end else if (flush_i) begin
      state <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else if (accept) begin
      state <= fast ? FIXUP : CALC;
      op <= mdop_t'(funct3_i);
      cnt <= '0;
      acc <= {{XLEN{1'b0}}, (fast && bz) ? {XLEN{1'b1}} : ma};
      rem <= (fast && bz) ? {1'b0, ma} : '0;
      opb <= mb;
      neg <= sgn;
      busy_o <= 1'b1;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        CALC: begin
          acc <= acc_nxt;
          rem <= rem_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIXUP;
        end
        FIXUP: begin
          result_o <= res;
          state <= DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed self-checking bench for muldiv_seq
module tb_muldiv_seq;
  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, flush_i = 1'b0;
  logic [2:0] funct3_i = '0;
  logic [31:0] a_i = '0, b_i = '0;
  logic stall_o, busy_o, done_o;
  logic [31:0] result_o;
  int vectors = 0, miscompares = 0;

  muldiv_seq #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .funct3_i(funct3_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    logic [63:0] up;
    ref_md = '0;
    case (f)
      3'd0: ref_md = a * b;
      3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); ref_md = sp[63:32]; end
      3'd2: begin sp = longint'($signed(a)) * longint'({32'b0, b}); ref_md = sp[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; ref_md = up[63:32]; end
      3'd4: if (b == 0) ref_md = '1;
            else begin sp = longint'($signed(a)) / longint'($signed(b)); ref_md = sp[31:0]; end
      3'd5: ref_md = (b == 0) ? '1 : a / b;
      3'd6: if (b == 0) ref_md = a;
            else begin sp = longint'($signed(a)) % longint'($signed(b)); ref_md = sp[31:0]; end
      default: ref_md = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : 33;
  endfunction

  // drives one start at posedge+1 and returns edges from accept edge to done_o
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] r, output logic st);
    funct3_i = f; a_i = a; b_i = b; start_i = 1'b1;
    #1 st = stall_o;
    @(posedge clk); #1 start_i = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1 lat++; end while (!done_o && lat < 60);
    r = result_o;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({stall_o, busy_o, done_o} !== 3'b000 || result_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset: stall/busy/done=%b result=%h want 000 00000000", {stall_o, busy_o, done_o}, result_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_timing;
    int bad;
    funct3_i = 3'd0; a_i = 32'd7; b_i = 32'hFFFFFFFD; start_i = 1'b1;
    #1;
    vectors++;
    if (stall_o !== 1'b1 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_start_stall: stall=%b busy=%b want 1 0", stall_o, busy_o);
    end
    @(posedge clk); #1 start_i = 1'b0;
    bad = 0;
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk); #1;
      if (k < 33 && (stall_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0)) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL mul_busy_window: %0d bad cycles want 0", bad);
    end
    vectors++;
    if (done_o !== 1'b1 || stall_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 32'hFFFFFFEB) begin
      miscompares++;
      $display("FAIL mul_done: done=%b stall=%b busy=%b result=%h want 1 0 0 ffffffeb", done_o, stall_o, busy_o, result_o);
    end
    @(posedge clk); #1;
    vectors++;
    if (done_o !== 1'b0 || result_o !== 32'hFFFFFFEB) begin
      miscompares++;
      $display("FAIL mul_done_pulse: done=%b result=%h want 0 ffffffeb", done_o, result_o);
    end
  endtask

  task automatic test_directed;
    logic [2:0] f [12];
    logic [31:0] a [12], b [12], e [12];
    int l [12];
    int lat;
    logic [31:0] r;
    logic st;
    f = '{3'd1, 3'd3, 3'd2, 3'd5, 3'd7, 3'd6, 3'd4, 3'd4, 3'd6, 3'd4, 3'd6, 3'd0};
    a = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9,
          32'h12345678, 32'h12345678, 32'h80000000, 32'h80000000, 32'd7};
    b = '{32'h80000000, 32'h80000000, 32'd2, 32'd7, 32'd7, 32'd2, 32'd2,
          32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD};
    e = '{32'h40000000, 32'h40000000, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD,
          32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'h0, 32'hFFFFFFEB};
    l = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 33};
    for (int i = 0; i < 12; i++) begin
      issue(f[i], a[i], b[i], lat, r, st);
      vectors++;
      if (r !== e[i]) begin
        miscompares++;
        $display("FAIL directed_%0d result: got %h want %h", i, r, e[i]);
      end
      vectors++;
      if (lat !== l[i]) begin
        miscompares++;
        $display("FAIL directed_%0d latency: got %0d want %0d", i, lat, l[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] r, a, b;
    logic [2:0] f;
    logic st;
    for (int i = 0; i < 3; i++) begin
      f = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom | 32'h1;
      issue(f, a, b, lat, r, st);
      vectors++;
      if (done_o !== 1'b1 || stall_o !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_done_cycle_%0d: done=%b stall=%b want 1 0", i, done_o, stall_o);
      end
      f = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom | 32'h1;
      issue(f, a, b, lat, r, st);
      vectors++;
      if (st !== 1'b1 || r !== ref_md(f, a, b) || lat !== 33) begin
        miscompares++;
        $display("FAIL b2b_second_%0d: stall=%b result=%h lat=%0d want 1 %h 33", i, st, r, lat, ref_md(f, a, b));
      end
    end
  endtask

  task automatic test_ignore_start;
    int lat, pulses;
    logic [31:0] r;
    funct3_i = 3'd5; a_i = 32'd1000; b_i = 32'd9; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    lat = 0; pulses = 0; r = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 6) begin start_i = 1'b1; funct3_i = 3'd0; a_i = 32'd3; b_i = 32'd5; end
      @(posedge clk); #1 start_i = 1'b0;
      if (done_o) begin pulses++; if (lat == 0) begin lat = k; r = result_o; end end
    end
    vectors++;
    if (r !== 32'd111 || lat !== 33 || pulses !== 1) begin
      miscompares++;
      $display("FAIL ignore_start: result=%h lat=%0d pulses=%0d want 0000006f 33 1", r, lat, pulses);
    end
  endtask

  task automatic test_flush;
    int lat, pulses;
    logic [31:0] prev, r;
    logic st;
    prev = result_o;
    funct3_i = 3'd4; a_i = 32'd5000; b_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1; start_i = 1'b1; funct3_i = 3'd0; a_i = 32'd2; b_i = 32'd2;
    @(posedge clk); #1 flush_i = 1'b0; start_i = 1'b0;
    vectors++;
    if (busy_o !== 1'b0 || stall_o !== 1'b0 || done_o !== 1'b0 || result_o !== prev) begin
      miscompares++;
      $display("FAIL flush_state: busy=%b stall=%b done=%b result=%h want 0 0 0 %h", busy_o, stall_o, done_o, result_o, prev);
    end
    pulses = 0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1 if (done_o) pulses++; end
    vectors++;
    if (pulses !== 0 || result_o !== prev) begin
      miscompares++;
      $display("FAIL flush_no_done: pulses=%0d result=%h want 0 %h", pulses, result_o, prev);
    end
    issue(3'd4, 32'hFFFFEC78, 32'd9, lat, r, st);
    vectors++;
    if (r !== ref_md(3'd4, 32'hFFFFEC78, 32'd9) || lat !== 33) begin
      miscompares++;
      $display("FAIL flush_restart: result=%h lat=%0d want %h 33", r, lat, ref_md(3'd4, 32'hFFFFEC78, 32'd9));
    end
  endtask

  task automatic test_random;
    int lat, m;
    logic [31:0] r, a, b;
    logic [2:0] f;
    logic st;
    for (int i = 0; i < 48; i++) begin
      f = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom; m = $urandom_range(0, 9);
      if (m == 0) b = '0;
      else if (m == 1) begin a = 32'h80000000; b = '1; end
      else if (m == 2) b = 32'($urandom_range(1, 15));
      issue(f, a, b, lat, r, st);
      vectors++;
      if (r !== ref_md(f, a, b)) begin
        miscompares++;
        $display("FAIL random_%0d f=%0d a=%h b=%h: got %h want %h", i, f, a, b, r, ref_md(f, a, b));
      end
      vectors++;
      if (lat !== exp_lat(f, a, b)) begin
        miscompares++;
        $display("FAIL random_%0d latency f=%0d: got %0d want %0d", i, f, lat, exp_lat(f, a, b));
      end
    end
  endtask

  task automatic test_midreset;
    int pulses;
    funct3_i = 3'd1; a_i = $urandom; b_i = $urandom; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({stall_o, busy_o, done_o} !== 3'b000 || result_o !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset: stall/busy/done=%b result=%h want 000 00000000", {stall_o, busy_o, done_o}, result_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1 if (done_o || busy_o) pulses++; end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL midreset_pending: active cycles=%0d want 0", pulses);
    end
  endtask

  initial begin
    test_reset;
    test_mul_timing;
    test_directed;
    test_back_to_back;
    test_ignore_start;
    test_flush;
    test_random;
    test_midreset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
